dram_responder: RTL and testbench



---
 rtl/dram_responder_pkg.sv | 21 ++
 rtl/dram_array.sv | 32 +++
 rtl/dram_responder.sv | 98 +++++++++
 tb/tb_dram_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_responder_pkg.sv
// Shared definitions for the DRAM responder.
// Holds the FSM state codes, the default latencies and the latency-counter type.
package dram_responder_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_WR_LATENCY = 1;

  // Latencies are 1..15, so four bits always hold latency-1.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] count_t;

  function automatic count_t load_count(input int latency);
    return count_t'(latency - 1);
  endfunction

endpackage

// File: rtl/dram_array.sv
// Synchronous single-port storage of 2^WIDTH words with a registered read port.
// The word array itself is never reset so it maps onto block RAM.
module dram_array #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // rdata only moves on a read, so it holds the last read word between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// Memory-side end of the processor DRAM interface: one access at a time with a
// programmable wait count, and a memBUSY/memDONE handshake for the control unit.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int WR_LATENCY = DEF_WR_LATENCY
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             memREAD,
  input  logic             memWRITE,
  input  logic [WIDTH-1:0] DRAM_addr,
  input  logic [WIDTH-1:0] DRAM_dataOut,
  output logic [WIDTH-1:0] DRAM_dataIn,
  output logic             memBUSY,
  output logic             memDONE,
  output logic             memERR
);

  logic [1:0]       state_reg, state_next;
  count_t           count_reg, count_next;
  logic [WIDTH-1:0] addr_reg, data_reg;
  logic             busy_reg, done_reg, err_reg;
  logic             accept, commit_rd, commit_wr;

  assign accept    = (state_reg == ST_IDLE) && (memREAD || memWRITE);
  assign commit_rd = (state_reg == ST_RD_WAIT) && (count_reg == '0);
  assign commit_wr = (state_reg == ST_WR_WAIT) && (count_reg == '0);

  // A write wins over a simultaneous read; the read is dropped.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (memWRITE) begin
          state_next = ST_WR_WAIT;
          count_next = load_count(WR_LATENCY);
        end else if (memREAD) begin
          state_next = ST_RD_WAIT;
          count_next = load_count(RD_LATENCY);
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (count_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          count_next = count_reg - count_t'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= commit_rd || commit_wr;
      if (accept) begin
        addr_reg <= DRAM_addr;
        data_reg <= DRAM_dataOut;
      end
      if ((state_reg == ST_IDLE) && memREAD && memWRITE) begin
        err_reg <= 1'b1;
      end
    end
  end

  dram_array #(
    .WIDTH(WIDTH)
  ) u_array (
    .clk  (Clk),
    .rst  (Rst),
    .we   (commit_wr),
    .re   (commit_rd),
    .addr (addr_reg),
    .wdata(data_reg),
    .rdata(DRAM_dataIn)
  );

  assign memBUSY = busy_reg;
  assign memDONE = done_reg;
  assign memERR  = err_reg;

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: three instances with different latencies, each checked
// cycle by cycle against a word-array model of the memory and its handshake.
module tb_dram_responder;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [2:0] rd_s = '0;
  logic [2:0] wr_s = '0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] din  [3];
  logic       busy [3];
  logic       done [3];
  logic       err  [3];

  int rd_lat [3] = '{2, 15, 1};
  int wr_lat [3] = '{1, 3, 2};

  logic [7:0] mem_m  [3][256];
  bit         known  [3][256];
  logic [7:0] last_m [3];
  bit         err_m  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  dram_responder #(.WIDTH(8), .RD_LATENCY(2), .WR_LATENCY(1)) dut0 (
    .Clk(Clk), .Rst(Rst), .memREAD(rd_s[0]), .memWRITE(wr_s[0]),
    .DRAM_addr(addr), .DRAM_dataOut(wdata), .DRAM_dataIn(din[0]),
    .memBUSY(busy[0]), .memDONE(done[0]), .memERR(err[0]));

  dram_responder #(.WIDTH(8), .RD_LATENCY(15), .WR_LATENCY(3)) dut1 (
    .Clk(Clk), .Rst(Rst), .memREAD(rd_s[1]), .memWRITE(wr_s[1]),
    .DRAM_addr(addr), .DRAM_dataOut(wdata), .DRAM_dataIn(din[1]),
    .memBUSY(busy[1]), .memDONE(done[1]), .memERR(err[1]));

  dram_responder #(.WIDTH(8), .RD_LATENCY(1), .WR_LATENCY(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .memREAD(rd_s[2]), .memWRITE(wr_s[2]),
    .DRAM_addr(addr), .DRAM_dataOut(wdata), .DRAM_dataIn(din[2]),
    .memBUSY(busy[2]), .memDONE(done[2]), .memERR(err[2]));

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      last_m[i] = 8'h00;
      err_m[i]  = 1'b0;
    end
  endtask

  // Leaves the caller just after a falling edge with Rst released.
  task automatic do_reset();
    Rst = 1'b1;
    model_reset();
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  // Request issued in cycle 0 (driven now, sampled at the next rising edge);
  // cycles 1..lat+2 are then checked. Ends mid cycle lat+2, so a following call
  // issues its request at the earliest legal cycle.
  task automatic txn(input int d, input bit rd, input bit wr,
                     input logic [7:0] a, input logic [7:0] dt, input bit poke);
    int lat;
    lat = wr ? wr_lat[d] : rd_lat[d];
    if (wr) begin
      mem_m[d][a] = dt;
      known[d][a] = 1'b1;
      if (rd) err_m[d] = 1'b1;
    end else begin
      last_m[d] = mem_m[d][a];
    end
    rd_s[d] = rd; wr_s[d] = wr; addr = a; wdata = dt;
    @(posedge Clk); #1;
    rd_s[d] = poke; wr_s[d] = 1'b0;
    addr  = poke ? 8'h30 : 8'($urandom);
    wdata = 8'($urandom);
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge Clk);
      if (k == 2) rd_s[d] = 1'b0;
      vectors++;
      if (busy[d] !== (k <= lat + 1)) begin
        miscompares++;
        $display("FAIL busy dut%0d cycle %0d: got %b want %b", d, k, busy[d], (k <= lat + 1));
      end
      vectors++;
      if (done[d] !== (k == lat + 1)) begin
        miscompares++;
        $display("FAIL done dut%0d cycle %0d: got %b want %b", d, k, done[d], (k == lat + 1));
      end
      if (k >= lat + 1) begin
        vectors++;
        if (din[d] !== last_m[d]) begin
          miscompares++;
          $display("FAIL dataIn dut%0d cycle %0d addr %h: got %h want %h", d, k, a, din[d], last_m[d]);
        end
      end
      if (k == lat + 2) begin
        vectors++;
        if (err[d] !== err_m[d]) begin
          miscompares++;
          $display("FAIL err dut%0d: got %b want %b", d, err[d], err_m[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({busy[d], done[d], err[d], din[d]} !== 11'h000) begin
        miscompares++;
        $display("FAIL reset dut%0d: got busy %b done %b err %b din %h want all 0",
                 d, busy[d], done[d], err[d], din[d]);
      end
    end
  endtask

  task automatic test_basic();
    txn(0, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0);
    txn(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
  endtask

  task automatic test_extremes();
    txn(0, 1'b0, 1'b1, 8'hFF, 8'hC3, 1'b0);
    txn(0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0);
    txn(0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
    txn(0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_both_strobes();
    txn(0, 1'b1, 1'b1, 8'h20, 8'h77, 1'b0);
    txn(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
  endtask

  task automatic test_ignored_read();
    txn(0, 1'b0, 1'b1, 8'h40, 8'($urandom), 1'b1);
    txn(0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    txn(1, 1'b1, 1'b1, 8'h05, 8'hAA, 1'b0);
    txn(1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
    wr_s[1] = 1'b1; addr = 8'h05; wdata = 8'hBB;
    @(posedge Clk); #1;
    wr_s[1] = 1'b0;
    @(posedge Clk); #2;
    Rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({busy[1], done[1], err[1], din[1]} !== 11'h000) begin
      miscompares++;
      $display("FAIL async_reset dut1: got busy %b done %b err %b din %h want all 0",
               busy[1], done[1], err[1], din[1]);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    txn(1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
  endtask

  task automatic test_latency_extremes();
    logic [7:0] v;
    v = 8'($urandom);
    txn(2, 1'b0, 1'b1, 8'h66, v, 1'b0);
    txn(2, 1'b1, 1'b0, 8'h66, 8'h00, 1'b0);
    txn(1, 1'b0, 1'b1, 8'h67, ~v, 1'b0);
    txn(1, 1'b1, 1'b0, 8'h67, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int d;
      logic [7:0] a;
      d = $urandom_range(0, 2);
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        txn(d, ($urandom_range(0, 7) == 0), 1'b1, a, 8'($urandom), 1'b0);
      end else begin
        for (int s = 0; s < 256 && !known[d][a]; s++) a = a + 8'd1;
        if (known[d][a]) txn(d, 1'b1, 1'b0, a, 8'($urandom), 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_both_strobes();
    test_ignored_read();
    test_reset_mid_write();
    test_latency_extremes();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
